// File: rtl/elastic_pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline slice.
package elastic_pipe_pkg;

  localparam int unsigned EP_MAX_DEPTH = 8;

  // Occupancy after one cycle of handshakes: +1 per accepted input, -1 per delivered output.
  function automatic int unsigned ep_cnt_next(input int unsigned cnt,
                                              input logic        in_xfer,
                                              input logic        out_xfer);
    return cnt + {31'd0, in_xfer} - {31'd0, out_xfer};
  endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One elastic register stage: holds valid/data and loads whenever it is empty or its successor moves.
module elastic_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             rdy
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic             data_en;

  assign rdy     = !valid_q || dn_ready;
  // Only real payloads are captured, and a flush leaves held data alone.
  assign data_en = rdy && up_valid && !flush;

  always_ff @(posedge clk) begin
    if (reset)      valid_q <= 1'b0;
    else if (flush) valid_q <= 1'b0;
    else if (rdy)   valid_q <= up_valid;
  end

  always_ff @(posedge clk) begin
    if (reset)        data_q <= '0;
    else if (data_en) data_q <= up_data;
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/elastic_pipe.sv
// DEPTH-stage valid/ready pipeline with bubble collapsing, synchronous flush and occupancy count.
module elastic_pipe
  import elastic_pipe_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  if (DEPTH < 1 || DEPTH > int'(EP_MAX_DEPTH)) begin : g_bad_depth
    $error("elastic_pipe: DEPTH out of range");
  end

  // Stage 0 faces upstream; stage DEPTH-1 drives the outputs. Ready ripples back from out_ready.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic             dn_r;
    logic             v;
    logic [WIDTH-1:0] d;
    logic             r;

    if (i == 0) begin : g_first
      assign up_v = in_valid;
      assign up_d = in_data;
    end else begin : g_mid
      assign up_v = g_stage[i-1].v;
      assign up_d = g_stage[i-1].d;
    end

    if (i == DEPTH - 1) begin : g_last
      assign dn_r = out_ready;
    end else begin : g_inner
      assign dn_r = g_stage[i+1].r;
    end

    elastic_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .up_valid (up_v),
      .up_data  (up_d),
      .dn_ready (dn_r),
      .valid    (v),
      .data     (d),
      .rdy      (r)
    );
  end

  assign in_ready  = g_stage[0].r && !flush;
  assign out_valid = g_stage[DEPTH-1].v;
  assign out_data  = g_stage[DEPTH-1].d;

  logic             in_xfer;
  logic             out_xfer;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Tracked incrementally so it updates on the same edge as the valid bits.
  always_comb begin
    count_d = CNT_W'(ep_cnt_next(32'(count_q), in_xfer, out_xfer));
    if (flush) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed and randomized checks of elastic_pipe at DEPTH=2 and DEPTH=3.
module tb_elastic_pipe;

  logic        clk = 1'b0;
  logic        reset;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_count;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_count;

  int checks   = 0;
  int failures = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  elastic_pipe #(.WIDTH(32), .DEPTH(2)) u_dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  elastic_pipe #(.WIDTH(32), .DEPTH(3)) u_dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    a_in_valid  = iv;
    a_in_data   = d;
    a_out_ready = ordy;
    a_flush     = fl;
    #2;
  endtask

  task automatic drv_b(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    b_in_valid  = iv;
    b_in_data   = d;
    b_out_ready = ordy;
    b_flush     = fl;
    #2;
  endtask

  initial begin
    reset = 1'b1;
    drv_a(1'b0, 32'h0, 1'b0, 1'b0);
    drv_b(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #2;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data",  a_out_data,       32'd0);
    chk("rst_count",     32'(a_count),     32'd0);
    chk("rst_in_ready",  32'(a_in_ready),  32'd1);
    chk("rst_b_count",   32'(b_count),     32'd0);

    // Fill at full throughput
    drv_a(1'b1, 32'h11, 1'b1, 1'b0);
    chk("fill0_ov", 32'(a_out_valid), 32'd0);
    tick();
    drv_a(1'b1, 32'h22, 1'b1, 1'b0);
    chk("fill1_ov",  32'(a_out_valid), 32'd0);
    chk("fill1_cnt", 32'(a_count),     32'd1);
    tick();
    drv_a(1'b1, 32'h33, 1'b1, 1'b0);
    chk("fill2_ov",  32'(a_out_valid), 32'd1);
    chk("fill2_d",   a_out_data,       32'h11);
    chk("fill2_cnt", 32'(a_count),     32'd2);
    chk("fill2_ir",  32'(a_in_ready),  32'd1);
    tick();
    drv_a(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fill3_d",   a_out_data,   32'h22);
    chk("fill3_cnt", 32'(a_count), 32'd2);
    tick();
    drv_a(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fill4_d",   a_out_data,   32'h33);
    chk("fill4_cnt", 32'(a_count), 32'd1);
    tick();
    drv_a(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fill5_ov",  32'(a_out_valid), 32'd0);
    chk("fill5_cnt", 32'(a_count),     32'd0);

    // Backpressure
    drv_a(1'b1, 32'hA0, 1'b0, 1'b0);
    tick();
    drv_a(1'b1, 32'hA1, 1'b0, 1'b0);
    chk("bp1_ir", 32'(a_in_ready), 32'd1);
    tick();
    drv_a(1'b1, 32'hA2, 1'b0, 1'b0);
    chk("bp2_cnt", 32'(a_count),     32'd2);
    chk("bp2_ir",  32'(a_in_ready),  32'd0);
    chk("bp2_ov",  32'(a_out_valid), 32'd1);
    chk("bp2_d",   a_out_data,       32'hA0);
    tick();
    drv_a(1'b0, 32'h0, 1'b0, 1'b0);
    chk("bp3_d",   a_out_data,   32'hA0);
    chk("bp3_cnt", 32'(a_count), 32'd2);
    tick();
    drv_a(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp4_d", a_out_data, 32'hA0);
    tick();
    drv_a(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp5_d",   a_out_data,   32'hA1);
    chk("bp5_cnt", 32'(a_count), 32'd1);
    tick();
    drv_a(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp6_ov", 32'(a_out_valid), 32'd0);

    // Simultaneous accept and drain while full
    drv_a(1'b1, 32'hC0, 1'b0, 1'b0);
    tick();
    drv_a(1'b1, 32'hC1, 1'b0, 1'b0);
    tick();
    drv_a(1'b1, 32'h77, 1'b1, 1'b0);
    chk("sim0_ir",  32'(a_in_ready), 32'd1);
    chk("sim0_cnt", 32'(a_count),    32'd2);
    chk("sim0_d",   a_out_data,      32'hC0);
    tick();
    drv_a(1'b0, 32'h0, 1'b1, 1'b0);
    chk("sim1_cnt", 32'(a_count), 32'd2);
    chk("sim1_d",   a_out_data,   32'hC1);
    tick();
    drv_a(1'b0, 32'h0, 1'b1, 1'b0);
    chk("sim2_d",   a_out_data,   32'h77);
    chk("sim2_cnt", 32'(a_count), 32'd1);
    tick();
    drv_a(1'b0, 32'h0, 1'b1, 1'b0);
    chk("sim3_cnt", 32'(a_count), 32'd0);

    // Flush with a concurrent input
    drv_a(1'b1, 32'hB0, 1'b0, 1'b0);
    tick();
    drv_a(1'b1, 32'hB1, 1'b0, 1'b0);
    tick();
    drv_a(1'b1, 32'hB2, 1'b0, 1'b1);
    chk("fl0_ir", 32'(a_in_ready),  32'd0);
    chk("fl0_ov", 32'(a_out_valid), 32'd1);
    tick();
    drv_a(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fl1_cnt", 32'(a_count),     32'd0);
    chk("fl1_ov",  32'(a_out_valid), 32'd0);
    tick();
    drv_a(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fl2_ov", 32'(a_out_valid), 32'd0);
    tick();
    drv_a(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fl3_ov", 32'(a_out_valid), 32'd0);

    // Bubble collapse on the 3-deep pipe
    drv_b(1'b1, 32'h5, 1'b0, 1'b0);
    tick();
    drv_b(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drv_b(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drv_b(1'b1, 32'h6, 1'b0, 1'b0);
    chk("bub0_d", b_out_data, 32'h5);
    tick();
    drv_b(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    drv_b(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bub1_cnt", 32'(b_count),     32'd2);
    chk("bub1_ir",  32'(b_in_ready),  32'd1);
    chk("bub1_d",   b_out_data,       32'h5);
    tick();
    drv_b(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bub2_ov", 32'(b_out_valid), 32'd1);
    chk("bub2_d",  b_out_data,       32'h6);
    tick();
    drv_b(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bub3_cnt", 32'(b_count), 32'd0);

    // Random traffic against a queue model on both pipes
    for (int n = 0; n < 3000; n++) begin
      a_in_valid  = 1'($urandom_range(0, 1));
      a_in_data   = $urandom;
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_flush     = ($urandom_range(0, 19) == 0);
      b_in_valid  = 1'($urandom_range(0, 1));
      b_in_data   = $urandom;
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_flush     = ($urandom_range(0, 24) == 0);
      #2;
      chk("rnd_a_cnt", 32'(a_count), 32'(qa.size()));
      chk("rnd_b_cnt", 32'(b_count), 32'(qb.size()));
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) chk("rnd_a_spurious", 32'(a_out_valid), 32'd0);
        else begin
          exp_v = qa.pop_front();
          chk("rnd_a_data", a_out_data, exp_v);
        end
      end
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) chk("rnd_b_spurious", 32'(b_out_valid), 32'd0);
        else begin
          exp_v = qb.pop_front();
          chk("rnd_b_data", b_out_data, exp_v);
        end
      end
      if (a_flush) begin
        chk("rnd_a_flush_ir", 32'(a_in_ready), 32'd0);
        qa.delete();
      end else if (a_in_valid && a_in_ready) qa.push_back(a_in_data);
      if (b_flush) begin
        chk("rnd_b_flush_ir", 32'(b_in_ready), 32'd0);
        qb.delete();
      end else if (b_in_valid && b_in_ready) qb.push_back(b_in_data);
      tick();
    end

    // Drain what is left
    for (int n = 0; n < 6; n++) begin
      drv_a(1'b0, 32'h0, 1'b1, 1'b0);
      drv_b(1'b0, 32'h0, 1'b1, 1'b0);
      if (a_out_valid) begin
        if (qa.size() == 0) chk("drain_a_spurious", 32'(a_out_valid), 32'd0);
        else begin
          exp_v = qa.pop_front();
          chk("drain_a_data", a_out_data, exp_v);
        end
      end
      if (b_out_valid) begin
        if (qb.size() == 0) chk("drain_b_spurious", 32'(b_out_valid), 32'd0);
        else begin
          exp_v = qb.pop_front();
          chk("drain_b_data", b_out_data, exp_v);
        end
      end
      tick();
    end
    chk("drain_a_left", 32'(qa.size()), 32'd0);
    chk("drain_b_left", 32'(qb.size()), 32'd0);
    chk("drain_a_cnt",  32'(a_count),   32'd0);
    chk("drain_b_cnt",  32'(b_count),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
